// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit: funct3 encodings,
// default counter reset value and the condition-evaluator result type.
package branch_predict_unit_pkg;

  // Conditional-branch funct3 encodings
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // Weakly not-taken
  localparam int CTR_INIT_DEF = 1;

  // Condition evaluation result
  typedef struct packed {
    logic legal;
    logic outcome;
  } br_cond_t;

endpackage

// File: rtl/branch_predict_unit_if.sv
// Core-side bundle for the branch predict unit: IF lookup plus EX resolution.
// master = pipeline side, slave = predictor side.
interface branch_predict_unit_if #(
  parameter int PC_W = 32
);
  // IF lookup
  logic [PC_W-1:0] pc_if;
  logic            pred_taken_if;
  // EX resolution
  logic            res_valid;
  logic            res_stall;
  logic            Branch;
  logic [2:0]      function3;
  logic [PC_W-1:0] pc_ex;
  logic            pred_taken_ex;
  logic            zero_flag;
  logic            carry_flag;
  logic            overflow_flag;
  logic            sign_flag;
  logic            branch_sel;
  logic            mispredict;

  modport master (
    output pc_if, res_valid, res_stall, Branch, function3, pc_ex, pred_taken_ex,
           zero_flag, carry_flag, overflow_flag, sign_flag,
    input  pred_taken_if, branch_sel, mispredict
  );

  modport slave (
    input  pc_if, res_valid, res_stall, Branch, function3, pc_ex, pred_taken_ex,
           zero_flag, carry_flag, overflow_flag, sign_flag,
    output pred_taken_if, branch_sel, mispredict
  );
endinterface

// File: rtl/branch_predict_unit_cond_eval.sv
// branch_cond_eval: combinational funct3 + ALU flags -> {legal, outcome}.
// Carry follows the subtract convention: carry=1 means no borrow (a >= b unsigned).
module branch_cond_eval
  import branch_predict_unit_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_carry,
  input  logic       i_overflow,
  input  logic       i_sign,
  output br_cond_t   o_res
);

  // Decode funct3; 010/011 are reserved and resolve as illegal, not taken
  always_comb begin
    o_res = '0;
    unique case (i_funct3)
      BR_BEQ:  o_res = '{legal: 1'b1, outcome:  i_zero};
      BR_BNE:  o_res = '{legal: 1'b1, outcome: ~i_zero};
      BR_BLT:  o_res = '{legal: 1'b1, outcome:  (i_sign ^ i_overflow)};
      BR_BGE:  o_res = '{legal: 1'b1, outcome: ~(i_sign ^ i_overflow)};
      BR_BLTU: o_res = '{legal: 1'b1, outcome: ~i_carry};
      BR_BGEU: o_res = '{legal: 1'b1, outcome:  i_carry};
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: PC-indexed BHT of saturating counters. Predicts at IF
// (combinational read, no bypass), resolves and updates at EX.
// Optional statistics counters: define BRANCH_STATS_EN.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CTR_W     = 2,
  parameter int CTR_INIT  = CTR_INIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_predict_unit_if.slave   bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]            stat_branches,
  output logic [31:0]            stat_mispredicts
`endif
);

  localparam int IDXW = $clog2(BHT_DEPTH);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(CTR_INIT);

  logic [CTR_W-1:0] r_bht [BHT_DEPTH];

  logic [IDXW-1:0]  w_idx_if;
  logic [IDXW-1:0]  w_idx_ex;
  logic [CTR_W-1:0] w_ctr_cur;
  logic [CTR_W-1:0] w_ctr_nxt;
  br_cond_t         w_res;
  logic             w_upd;
  logic             w_mis;
  logic             w_unused;

  // Word-aligned PCs: bits [1:0] skipped, upper bits alias by design
  assign w_idx_if = bus.pc_if[IDXW+1:2];
  assign w_idx_ex = bus.pc_ex[IDXW+1:2];
  assign w_unused = ^{bus.pc_if, bus.pc_ex};

  branch_cond_eval u_cond (
    .i_funct3   (bus.function3),
    .i_zero     (bus.zero_flag),
    .i_carry    (bus.carry_flag),
    .i_overflow (bus.overflow_flag),
    .i_sign     (bus.sign_flag),
    .o_res      (w_res)
  );

  assign w_upd = bus.res_valid & ~bus.res_stall & bus.Branch & w_res.legal;
  assign w_mis = w_upd & (w_res.outcome != bus.pred_taken_ex);

  assign bus.branch_sel    = w_upd & w_res.outcome;
  assign bus.mispredict    = w_mis;
  assign bus.pred_taken_if = r_bht[w_idx_if][CTR_W-1];

  assign w_ctr_cur = r_bht[w_idx_ex];

  // Saturating increment on taken, decrement on not taken
  always_comb begin
    w_ctr_nxt = w_ctr_cur;
    if (w_res.outcome) begin
      if (w_ctr_cur != CTR_MAX) w_ctr_nxt = w_ctr_cur + 1'b1;
    end else begin
      if (w_ctr_cur != '0) w_ctr_nxt = w_ctr_cur - 1'b1;
    end
  end

  // BHT storage: reset wins over a same-cycle update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= CTR_RST;
    end else if (w_upd) begin
      r_bht[w_idx_ex] <= w_ctr_nxt;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mp;

  // Resolved-branch and misprediction counts, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else begin
      if (w_upd && (r_stat_br != 32'hFFFF_FFFF)) r_stat_br <= r_stat_br + 32'd1;
      if (w_mis && (r_stat_mp != 32'hFFFF_FFFF)) r_stat_mp <= r_stat_mp + 32'd1;
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mp;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit (default parameters, CTR_W=2, CTR_INIT=1).
// Statistics checks are compiled in when BRANCH_STATS_EN is defined.
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  logic gclk;
  logic rst;
  int   n_tests;
  int   n_fail;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predict_unit_if #(.PC_W(32)) bus ();

  branch_predict_unit #(
    .PC_W(32), .BHT_DEPTH(64), .CTR_W(2), .CTR_INIT(1)
  ) dut (
    .clk (gclk),
    .rst (rst),
    .bus (bus)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge, outputs are sampled 1ns later
  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic idle();
    bus.res_valid = 0; bus.res_stall = 0; bus.Branch = 0; bus.function3 = 3'b000;
    bus.pc_ex = '0; bus.pred_taken_ex = 0;
    bus.zero_flag = 0; bus.carry_flag = 0; bus.overflow_flag = 0; bus.sign_flag = 0;
    #1;
  endtask

  task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic pred,
                    input logic z, input logic c, input logic v, input logic s);
    bus.res_valid = 1; bus.res_stall = 0; bus.Branch = 1; bus.function3 = f3;
    bus.pc_ex = pc; bus.pred_taken_ex = pred;
    bus.zero_flag = z; bus.carry_flag = c; bus.overflow_flag = v; bus.sign_flag = s;
    #1;
  endtask

  task automatic do_reset();
    rst = 1; idle();
    tick(); tick();
    rst = 0; #1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1; bus.pc_if = '0; idle();

    // Reset state
    do_reset();
    bus.pc_if = 32'h100; #1; chk("rst_pred_100", bus.pred_taken_if, 0);
    bus.pc_if = 32'h1FC; #1; chk("rst_pred_1fc", bus.pred_taken_if, 0);
    chk("rst_sel", bus.branch_sel, 0);
    chk("rst_mis", bus.mispredict, 0);
`ifdef BRANCH_STATS_EN
    chk("rst_stat_br", stat_branches, 0);
    chk("rst_stat_mp", stat_mispredicts, 0);
`endif

    // Saturation at pc 0x40 (entry 16): 1 -> 2 -> 3 -> 3
    bus.pc_if = 32'h40;
    br(BR_BEQ, 32'h40, 0, 1, 0, 0, 0);
    chk("beq1_sel", bus.branch_sel, 1);
    chk("beq1_mis", bus.mispredict, 1);
    chk("beq1_pred_old", bus.pred_taken_if, 0);
    tick(); idle();
    chk("ctr2_pred", bus.pred_taken_if, 1);
    bus.pc_if = 32'h140; #1;
    chk("alias_pred", bus.pred_taken_if, 1);
    bus.pc_if = 32'h40;
    br(BR_BEQ, 32'h40, 1, 1, 0, 0, 0);
    chk("beq2_mis", bus.mispredict, 0);
    tick();
    br(BR_BEQ, 32'h40, 1, 1, 0, 0, 0);
    tick(); idle();
    chk("ctr3_sat_pred", bus.pred_taken_if, 1);
    br(BR_BEQ, 32'h40, 1, 0, 0, 0, 0);
    chk("beqnt_sel", bus.branch_sel, 0);
    chk("beqnt_mis", bus.mispredict, 1);
    tick(); idle();
    chk("ctr2_down_pred", bus.pred_taken_if, 1);
    br(BR_BEQ, 32'h40, 1, 0, 0, 0, 0);
    tick(); idle();
    chk("ctr1_down_pred", bus.pred_taken_if, 0);

    // Branch types (combinational only, no edge taken)
    br(BR_BLT, 32'h200, 0, 0, 0, 0, 1);
    chk("blt_sel", bus.branch_sel, 1);
    chk("blt_mis", bus.mispredict, 1);
    br(BR_BGEU, 32'h204, 1, 0, 1, 0, 0);
    chk("bgeu_sel", bus.branch_sel, 1);
    chk("bgeu_mis", bus.mispredict, 0);
    br(BR_BNE, 32'h208, 1, 0, 0, 0, 0);
    chk("bne_sel", bus.branch_sel, 1);
    br(BR_BGE, 32'h210, 0, 0, 0, 1, 1);
    chk("bge_sel", bus.branch_sel, 1);
    br(BR_BLTU, 32'h214, 1, 0, 0, 0, 0);
    chk("bltu_t_sel", bus.branch_sel, 1);
    br(BR_BLTU, 32'h218, 1, 0, 1, 0, 0);
    chk("bltu_nt_sel", bus.branch_sel, 0);
    chk("bltu_nt_mis", bus.mispredict, 1);
    br(BR_BLT, 32'h21C, 1, 0, 0, 1, 1);
    chk("blt_nt_sel", bus.branch_sel, 0);
    br(BR_BEQ, 32'h220, 0, 1, 0, 0, 0);
    bus.res_valid = 0; #1;
    chk("novalid_sel", bus.branch_sel, 0);
    chk("novalid_mis", bus.mispredict, 0);
    bus.res_valid = 1; bus.Branch = 0; #1;
    chk("nobranch_sel", bus.branch_sel, 0);
    idle();

    // Illegal funct3 at pc 0x0C (entry 3): no outputs, no table change
    bus.pc_if = 32'h0C;
    br(3'b010, 32'h0C, 1, 1, 1, 1, 1);
    chk("ill010_sel", bus.branch_sel, 0);
    chk("ill010_mis", bus.mispredict, 0);
    tick();
    br(3'b011, 32'h0C, 1, 1, 1, 1, 1);
    chk("ill011_sel", bus.branch_sel, 0);
    tick(); idle();
    chk("ill_no_update", bus.pred_taken_if, 0);

    // Stall then read-during-write at pc 0x80
    bus.pc_if = 32'h80;
    br(BR_BEQ, 32'h80, 0, 1, 0, 0, 0);
    bus.res_stall = 1; #1;
    chk("stall_sel", bus.branch_sel, 0);
    chk("stall_mis", bus.mispredict, 0);
    tick(); tick();
    chk("stall_no_update", bus.pred_taken_if, 0);
    bus.res_stall = 0; #1;
    chk("rel_sel", bus.branch_sel, 1);
    chk("rdw_old", bus.pred_taken_if, 0);
    tick(); idle();
    chk("rdw_new", bus.pred_taken_if, 1);

    // Reset mid-operation: train 0x40 to 3, reset with a taken update pending
    bus.pc_if = 32'h40;
    br(BR_BEQ, 32'h40, 0, 1, 0, 0, 0); tick();
    br(BR_BEQ, 32'h40, 1, 1, 0, 0, 0); tick();
    idle();
    chk("train3_pred", bus.pred_taken_if, 1);
    br(BR_BEQ, 32'h40, 1, 1, 0, 0, 0);
    rst = 1; #1;
    tick();
    rst = 0; idle();
    chk("midrst_pred40", bus.pred_taken_if, 0);
    bus.pc_if = 32'h80; #1;
    chk("midrst_pred80", bus.pred_taken_if, 0);
`ifdef BRANCH_STATS_EN
    chk("midrst_stat_br", stat_branches, 0);
    chk("midrst_stat_mp", stat_mispredicts, 0);
`endif
    // One taken update from CTR_INIT=1 must reach 2 (predict taken)
    bus.pc_if = 32'h40;
    br(BR_BEQ, 32'h40, 0, 1, 0, 0, 0); tick(); idle();
    chk("midrst_init1", bus.pred_taken_if, 1);

`ifdef BRANCH_STATS_EN
    // 10 resolved, 3 mispredicted; stalled and illegal cycles excluded
    do_reset();
    for (int i = 0; i < 10; i++) begin
      br(BR_BEQ, 32'h400 + 32'(i * 4), (i < 3) ? 1'b0 : 1'b1, 1, 0, 0, 0);
      tick();
    end
    br(BR_BEQ, 32'h440, 0, 1, 0, 0, 0);
    bus.res_stall = 1; #1; tick();
    br(3'b010, 32'h444, 0, 1, 0, 0, 0); tick();
    idle();
    chk("stat_br", stat_branches, 10);
    chk("stat_mp", stat_mispredicts, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the EX-stage branch-condition logic. It resolves conditional branches from ALU flags and funct3, and also predicts branch direction at fetch.
- The prediction comes from a PC-indexed table of saturating counters (BHT).
- It reports mispredictions to the hazard/flush logic.
- Sits between IF (prediction lookup) and EX (resolution and table update) of the pipelined core.

Parameters:
- PC_W, 32, program-counter width.
- BHT_DEPTH, 64, number of counter entries; power of two, 2..256.
- CTR_W, 2, counter width in bits; 1..4.
- CTR_INIT, 1, counter reset value (weakly not-taken); must be < 2**CTR_W.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- pc_if  in  PC_W  PC of the instruction being fetched.
- pred_taken_if  out  1  predicted direction for pc_if (combinational).
- res_valid  in  1  EX holds a valid instruction this cycle.
- res_stall  in  1  EX stalled; suppresses the update.
- Branch  in  1  EX instruction is a conditional branch.
- function3  in  3  funct3 of the EX instruction.
- pc_ex  in  PC_W  PC of the EX instruction.
- pred_taken_ex  in  1  prediction carried down the pipe with the instruction.
- zero_flag, carry_flag, overflow_flag, sign_flag  in  1 each  ALU flags for the EX compare.
- branch_sel  out  1  actual outcome: take the branch (combinational).
- mispredict  out  1  actual outcome differs from pred_taken_ex (combinational).
- stat_branches  out  32  resolved-branch count (only with the optional feature).
- stat_mispredicts  out  32  misprediction count (only with the optional feature).

Behaviour:
- Index: idx = PC[IDXW+1:2], where IDXW = log2(BHT_DEPTH). The same slice is used for pc_if and pc_ex.
- Prediction:
  - pred_taken_if = MSB of bht[idx(pc_if)].
  - Purely combinational, zero latency.
- Condition evaluation, only when Branch=1:
  - 000 (BEQ): zero_flag.
  - 001 (BNE): ~zero_flag.
  - 100 (BLT): sign_flag ^ overflow_flag.
  - 101 (BGE): ~(sign_flag ^ overflow_flag).
  - 110 (BLTU): ~carry_flag.
  - 111 (BGEU): carry_flag.
  - 010 and 011 are illegal: outcome 0 and the instruction is not counted as a branch.
- Qualifying: upd = res_valid & ~res_stall & Branch & legal funct3.
- Outputs gated by the qualifier:
  - branch_sel = upd & outcome.
  - mispredict = upd & (outcome != pred_taken_ex).
  - Both are 0 whenever upd=0.
- Table update, on the rising edge when upd=1:
  - outcome=1: bht[idx(pc_ex)] increments, saturating at 2**CTR_W-1.
  - outcome=0: bht[idx(pc_ex)] decrements, saturating at 0.
  - Exactly one entry changes per cycle.
- Read-during-write: if idx(pc_if) == idx(pc_ex) in an update cycle, pred_taken_if returns the pre-update value. There is no bypass.
- Stall: res_stall=1 holds the table unchanged and forces branch_sel and mispredict to 0. The same instruction is resolved in the cycle after the stall releases.
- Reset: on a clk edge with rst=1:
  - Every entry is set to CTR_INIT.
  - Statistics counters clear to 0.
  - rst overrides a simultaneous update.
  - Combinational outputs are valid in the first cycle after reset: pred_taken_if = MSB of CTR_INIT, i.e. 0 with the default CTR_INIT=1.
  - Reset in the middle of a loop drops all history and applies no partial update.
- Aliasing: PCs that differ only above bit IDXW+1 share an entry. This is expected and needs no detection.
- CTR_W=1 degenerates to a last-outcome predictor.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined:
  - stat_branches increments on every upd cycle.
  - stat_mispredicts increments on every upd & mispredict cycle.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- When undefined: both ports are absent; there are no counters and no extra area.

Decomposition:
- Shared defines file:
  - funct3 encodings: BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU.
  - Default CTR_INIT.
- Sub-module branch_cond_eval: combinational funct3 and flags to {legal, outcome}. It is reused by any future branch-target unit.
- BHT array, saturation logic and statistics counters stay in the top module.

Test Plan:
- Prediction after reset:
  - Stimulus: after rst, pc_if = 0x100, 0x1FC.
  - Response: pred_taken_if = 0 for both.
- Counter saturation:
  - Stimulus: three taken BEQs (zero_flag=1) at pc_ex = 0x40, then pc_if = 0x40.
  - Response: bht[16] goes 1 → 2 → 3 → 3; pred_taken_if = 1 after the first update.
  - Follow-up: two not-taken updates give counter 1 and pred_taken_if = 0.
- Misprediction, branch types and illegal funct3:
  - BLT with sign=1, overflow=0, pred_taken_ex=0 → branch_sel=1, mispredict=1.
  - BGEU with carry=1, pred_taken_ex=1 → mispredict=0.
  - funct3 = 010 with Branch=1 → branch_sel=0, mispredict=0, no table change.
- Stall and read-during-write:
  - Stimulus: res_stall=1 for 2 cycles, then a taken branch at pc_ex = pc_if = 0x80.
  - Response: no update while stalled; in the update cycle pred_taken_if shows the old value; the next cycle shows the new value.
- Reset mid-operation:
  - Stimulus: train entry 0x40 to 3, then assert rst in the same cycle as a taken update.
  - Response: entry = 1; stats = 0 (with BRANCH_STATS_EN).
- Statistics (BRANCH_STATS_EN):
  - Stimulus: 10 resolved branches, 3 of them mispredicted.
  - Response: stat_branches = 10, stat_mispredicts = 3.
  - Stalled and illegal cycles are not counted.
